cache_fill_arbiter: RTL and testbench

- Sequences the single shared multi-cycle main memory between the I-cache miss path, the D-cache miss path and the D-side write-through store path of the cpu.
- Fills one 8-word cache block per miss, issuing one pipelined read per cycle, and steers the returned words to the requesting cache.
- Sits between the two caches and the memory model that replaces the separate instruction and data memories.

---
 rtl/cache_fill_arbiter_pkg.sv | 10 +
 rtl/cache_fill_arbiter_if.sv | 55 +++++
 rtl/cache_fill_arbiter_fill_counter.sv | 38 +++
 rtl/cache_fill_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and default geometry for the cache fill arbiter.
package cache_arb_pkg;

    localparam int WORDS_PER_BLOCK_DEF = 8;
    localparam int MEM_LATENCY_DEF     = 4;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D, GNT_DW} grant_t;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter.
// crit_ready exists only when CRITICAL_WORD_FIRST_EN is defined.
interface cache_fill_arbiter_if #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_valid;
    logic [DATA_W-1:0] fill_data;
    logic [WORD_W-1:0] fill_word;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_done;
    logic              busy;
`ifdef CRITICAL_WORD_FIRST_EN
    logic              crit_ready;
`endif

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
        output i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy
`ifdef CRITICAL_WORD_FIRST_EN
        , output crit_ready
`endif
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
        input  i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy
`ifdef CRITICAL_WORD_FIRST_EN
        , input crit_ready
`endif
    );

endinterface

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Loadable modulo-N word counter; o_last flags the final word of a wrap
// that began at the loaded value.
module fill_counter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [$clog2(N)-1:0] i_load_val,
    input  logic                 i_inc,
    output logic [$clog2(N)-1:0] o_cnt,
    output logic                 o_last
);
    localparam int W = $clog2(N);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_start;
    logic [W-1:0] w_cnt_next;

    // N is a power of two, so the natural W-bit wrap is the modulo.
    assign w_cnt_next = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_start <= '0;
        end else if (i_load) begin
            r_cnt   <= i_load_val;
            r_start <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (w_cnt_next == r_start);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory between I-fill, D-fill and D write-through.
// Define CRITICAL_WORD_FIRST_EN to start fills at the missed word.
module cache_fill_arbiter
    import cache_arb_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int MEM_LATENCY     = MEM_LATENCY_DEF,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_fill_arbiter_if.master bus
);
    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W  = WORD_W + 1;
    localparam int LAT_W  = $clog2(MEM_LATENCY) + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    arb_state_t        r_state, w_next_state;
    grant_t            r_grant, w_gnt;
    logic [ADDR_W-1:0] r_base, w_miss_addr;
    logic              r_issuing;
    logic [LAT_W-1:0]  r_wait;
    logic [DATA_W-1:0] r_fill_data;
    logic [WORD_W-1:0] r_fill_word, w_start_idx, w_issue_cnt, w_ret_cnt;
    logic              r_i_we, r_d_we, r_i_done, r_d_done, r_wr_done;
    logic              w_issue_last, w_ret_last, w_issue, w_ret_valid;
    logic              w_wr_cycle, w_load, w_fill_end, w_wr_end;
    logic              w_wr_req, w_d_req, w_i_req;

    // A request is still high during its own done cycle; mask it so it is not re-granted.
    assign w_wr_req = bus.d_wr_req & ~r_wr_done;
    assign w_d_req  = bus.d_miss   & ~r_d_done;
    assign w_i_req  = bus.i_miss   & ~r_i_done;

    assign w_miss_addr = (w_gnt == GNT_I) ? bus.i_miss_addr : bus.d_miss_addr;
`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start_idx = w_miss_addr[OFF_W-1:1];
`else
    assign w_start_idx = '0;
`endif

    assign w_load      = (w_gnt == GNT_I) || (w_gnt == GNT_D);
    assign w_issue     = (r_state == FILL) && r_issuing;
    assign w_ret_valid = (r_state == FILL) && bus.mem_valid;
    assign w_wr_cycle  = (r_state == WRITE) && (r_wait == LAT_W'(MEM_LATENCY - 1));

    fill_counter #(.N(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_start_idx),
        .i_inc(w_issue), .o_cnt(w_issue_cnt), .o_last(w_issue_last)
    );

    fill_counter #(.N(WORDS_PER_BLOCK)) u_ret_cnt (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_start_idx),
        .i_inc(w_ret_valid), .o_cnt(w_ret_cnt), .o_last(w_ret_last)
    );

    always_comb begin
        w_next_state = r_state;
        w_gnt        = GNT_NONE;
        w_fill_end   = 1'b0;
        w_wr_end     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_gnt        = GNT_DW;
                    w_next_state = WRITE;
                end else if (w_d_req) begin
                    w_gnt        = GNT_D;
                    w_next_state = FILL;
                end else if (w_i_req) begin
                    w_gnt        = GNT_I;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (w_ret_valid && w_ret_last) begin
                    w_fill_end   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                if (r_wait == '0) begin
                    w_wr_end     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= GNT_NONE;
            r_base      <= '0;
            r_issuing   <= 1'b0;
            r_wait      <= '0;
            r_fill_data <= '0;
            r_fill_word <= '0;
            r_i_we      <= 1'b0;
            r_d_we      <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_gnt != GNT_NONE) r_grant <= w_gnt;
            if (w_load) begin
                r_base    <= w_miss_addr & BASE_MASK;
                r_issuing <= 1'b1;
            end else if (w_issue && w_issue_last) begin
                r_issuing <= 1'b0;
            end
            if (w_gnt == GNT_DW) r_wait <= LAT_W'(MEM_LATENCY - 1);
            else if ((r_state == WRITE) && (r_wait != '0)) r_wait <= r_wait - 1'b1;
            if (w_ret_valid) begin
                r_fill_data <= bus.mem_data_out;
                r_fill_word <= w_ret_cnt;
            end
            r_i_we    <= w_ret_valid && (r_grant == GNT_I);
            r_d_we    <= w_ret_valid && (r_grant == GNT_D);
            r_i_done  <= w_fill_end && (r_grant == GNT_I);
            r_d_done  <= w_fill_end && (r_grant == GNT_D);
            r_wr_done <= w_wr_end;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WORD_W-1:0] r_crit_idx;
    logic              r_crit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crit_idx <= '0;
            r_crit     <= 1'b0;
        end else begin
            if (w_load) r_crit_idx <= w_start_idx;
            r_crit <= w_ret_valid && (w_ret_cnt == r_crit_idx);
        end
    end

    assign bus.crit_ready = r_crit;
`endif

    assign bus.mem_en      = w_issue | w_wr_cycle;
    assign bus.mem_wr      = w_wr_cycle;
    assign bus.mem_addr    = w_wr_cycle ? bus.d_wr_addr :
                             w_issue    ? (r_base | ADDR_W'({w_issue_cnt, 1'b0})) : '0;
    assign bus.mem_data_in = w_wr_cycle ? bus.d_wr_data : '0;
    assign bus.fill_data   = r_fill_data;
    assign bus.fill_word   = r_fill_word;
    assign bus.i_fill_we   = r_i_we;
    assign bus.d_fill_we   = r_d_we;
    assign bus.i_fill_done = r_i_done;
    assign bus.d_fill_done = r_d_done;
    assign bus.d_wr_done   = r_wr_done;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with an addr-as-data memory model.
module tb_cache_fill_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) bus ();

    cache_fill_arbiter #(
        .WORDS_PER_BLOCK(8), .MEM_LATENCY(LAT), .ADDR_W(16), .DATA_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Memory model: every read returns its own address LAT cycles later; not reset.
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];
    logic           inj_valid = 1'b0;

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], bus.mem_en & ~bus.mem_wr};
        pa[0] <= bus.mem_addr;
        for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end

    assign bus.mem_valid    = pv[LAT-1] | inj_valid;
    assign bus.mem_data_out = pa[LAT-1];

    typedef struct {
        logic        is_i;
        logic [2:0]  word;
        logic [15:0] data;
        logic        first;
    } fill_exp_t;

    fill_exp_t   fill_q[$];
    logic [15:0] addr_q[$];
    fill_exp_t   e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push_fill(input logic is_i, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        int          start;
        int          w;
        base  = addr & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(addr[3:1]);
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            w = (start + k) % 8;
            a = base | 16'(w << 1);
            addr_q.push_back(a);
            fill_q.push_back('{is_i, 3'(w), a, (k == 0)});
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return bus.busy;
            1:       return bus.i_fill_done;
            2:       return bus.d_fill_done;
            default: return bus.d_wr_done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n;
        n = 0;
        while (n < 200 && sel_sig(sel) !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel_sig(sel)), 32'd1);
    endtask

    // Monitor: compares issued reads and fill writes against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b0) begin
                chk("rd_data_in", 32'(bus.mem_data_in), 32'd0);
                if (addr_q.size() == 0) chk("rd_unexp", 32'd1, 32'd0);
                else chk("rd_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
            end
            if (bus.i_fill_we === 1'b1 || bus.d_fill_we === 1'b1) begin
                if (fill_q.size() == 0) begin
                    chk("we_unexp", 32'({bus.i_fill_we, bus.d_fill_we}), 32'd0);
                end else begin
                    e = fill_q.pop_front();
                    chk("we_tgt", 32'({bus.i_fill_we, bus.d_fill_we}), e.is_i ? 32'd2 : 32'd1);
                    chk("fill_word", 32'(bus.fill_word), 32'(e.word));
                    chk("fill_data", 32'(bus.fill_data), 32'(e.data));
`ifdef CRITICAL_WORD_FIRST_EN
                    chk("crit_ready", 32'(bus.crit_ready), 32'(e.first));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nv;
        int nwe;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = '0;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = '0;
        bus.d_wr_req    = 1'b0;
        bus.d_wr_addr   = '0;
        bus.d_wr_data   = '0;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_mem", 32'({bus.mem_en, bus.mem_wr, bus.mem_addr}), 32'd0);
        chk("rst_data", {bus.mem_data_in, bus.fill_data}, 32'd0);
        chk("rst_flags", 32'({bus.fill_word, bus.i_fill_we, bus.d_fill_we, bus.i_fill_done,
                              bus.d_fill_done, bus.d_wr_done, bus.busy}), 32'd0);

        // Stray mem_valid while idle.
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        nwe = 0;
        repeat (3) begin
            nwe += int'(bus.i_fill_we | bus.d_fill_we);
            @(negedge clk);
        end
        chk("idle_valid_we", 32'(nwe), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Plain I fill.
        push_fill(1'b1, 16'h0046);
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h0046;
        wait_for(0, "i_fill_start");
        t0 = cyc;
        wait_for(1, "i_fill_done");
        chk("i_fill_len", 32'(cyc - t0), 32'd12);
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk("i_fill_q", 32'(fill_q.size() + addr_q.size()), 32'd0);

        // Simultaneous D and I misses: D first, one idle cycle, then I.
        push_fill(1'b0, 16'h1230);
        push_fill(1'b1, 16'h00A0);
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h1230;
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h00A0;
        wait_for(0, "d_first_start");
        t0 = cyc;
        wait_for(2, "d_first_done");
        chk("d_fill_len", 32'(cyc - t0), 32'd12);
        chk("gap_idle", 32'(bus.busy), 32'd0);
        chk("gap_no_i_done", 32'(bus.i_fill_done), 32'd0);
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk("i_after_d", 32'(bus.busy), 32'd1);
        wait_for(1, "i_after_d_done");
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk("di_q", 32'(fill_q.size() + addr_q.size()), 32'd0);

        // Store with a D miss pending: write wins, then the fill.
        push_fill(1'b0, 16'h3010);
        bus.d_wr_req    = 1'b1;
        bus.d_wr_addr   = 16'h2002;
        bus.d_wr_data   = 16'hBEEF;
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = 16'h3010;
        wait_for(0, "wr_start");
        t0 = cyc;
        chk("wr_strobe", 32'({bus.mem_en, bus.mem_wr}), 32'd3);
        chk("wr_addr", 32'(bus.mem_addr), 32'h2002);
        chk("wr_data", 32'(bus.mem_data_in), 32'hBEEF);
        @(negedge clk);
        chk("wr_single", 32'(bus.mem_en), 32'd0);
        wait_for(3, "wr_done");
        chk("wr_done_lat", 32'(cyc - t0), 32'd4);
        bus.d_wr_req = 1'b0;
        @(negedge clk);
        chk("d_after_wr", 32'({bus.busy, bus.mem_en, bus.mem_wr}), 32'd6);
        wait_for(2, "d_after_wr_done");
        bus.d_miss = 1'b0;
        @(negedge clk);
        chk("wr_q", 32'(fill_q.size() + addr_q.size()), 32'd0);

        // Reset on the third return; late returns must be dropped.
        push_fill(1'b1, 16'h0100);
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h0100;
        nv = 0;
        for (int n = 0; n < 100 && nv < 3; n++) begin
            @(negedge clk);
            if (bus.mem_valid === 1'b1) nv++;
        end
        chk("rst_third_ret", 32'(nv), 32'd3);
        #1 rst = 1'b1;
        bus.i_miss = 1'b0;
        #1 chk("rst_mid_outs", 32'({bus.mem_en, bus.i_fill_we, bus.busy, bus.fill_word,
                                   bus.fill_data}), 32'd0);
        fill_q.delete();
        addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nwe = 0;
        nv  = 0;
        repeat (10) begin
            @(negedge clk);
            nwe += int'(bus.i_fill_we | bus.d_fill_we);
            nv  += int'(bus.mem_valid);
        end
        chk("late_ret_we", 32'(nwe), 32'd0);
        chk("late_ret_busy", 32'(bus.busy), 32'd0);

        push_fill(1'b1, 16'h0046);
        bus.i_miss      = 1'b1;
        bus.i_miss_addr = 16'h0046;
        wait_for(0, "post_rst_start");
        t0 = cyc;
        wait_for(1, "post_rst_done");
        chk("post_rst_len", 32'(cyc - t0), 32'd12);
        bus.i_miss = 1'b0;
        @(negedge clk);
        chk("post_rst_q", 32'(fill_q.size() + addr_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
